// File: rtl/token_ring_arbiter_if.sv
// token_ring_arbiter_if: request/grant bundle between clients and the token ring arbiter.
interface token_ring_arbiter_if #(
    parameter int N_CLIENTS = 3
);
    localparam int PTR_W = $clog2(N_CLIENTS);
    logic [N_CLIENTS-1:0] req;
    logic [N_CLIENTS-1:0] ack;
    logic [PTR_W-1:0] sel;
    logic [PTR_W-1:0] owner;
    logic busy;
    logic preempt;
    modport master (output req, input ack, sel, busy, owner, preempt);
    modport slave (input req, output ack, sel, busy, owner, preempt);
endinterface

// File: rtl/token_ring_arbiter.sv
// token_ring_arbiter: N-client token-passing arbiter with per-client IDLE/READY/BUSY controllers,
// optional skip-to-requester rotation, hold-time preemption and a release lock.
module token_ring_arbiter #(
    parameter int N_CLIENTS = 3,
    parameter bit SKIP_IDLE = 1'b0,
    parameter int HOLD_MAX = 0
) (
    input logic clk,
    input logic rst_n,
    token_ring_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(N_CLIENTS);
    localparam int CNT_W = HOLD_MAX > 1 ? $clog2(HOLD_MAX) : 1;
    typedef enum logic [1:0] {IDLE, READY, BUSY} state_t;
    state_t st_q [N_CLIENTS];
    state_t st_d [N_CLIENTS];
    logic [PTR_W-1:0] ptr_q, ptr_d, owner, skip_ptr, idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CLIENTS-1:0] lock_q, lock_d, elig, ack;
    logic preempt_q, preempt_d, busy, in_ready, in_busy, release_c, revoke, found;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return p == PTR_W'(N_CLIENTS - 1) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CLIENTS; i++) st_q[i] <= IDLE;
            ptr_q <= '0;
            cnt_q <= '0;
            lock_q <= '0;
            preempt_q <= 1'b0;
        end else begin
            st_q <= st_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            lock_q <= lock_d;
            preempt_q <= preempt_d;
        end
    end

    always_comb begin
        owner = '0;
        in_ready = 1'b0;
        in_busy = 1'b0;
        ack = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            ack[i] = st_q[i] == BUSY;
            if (st_q[i] != IDLE) owner = PTR_W'(i);
            in_ready |= st_q[i] == READY;
            in_busy |= st_q[i] == BUSY;
        end
    end

    assign busy = in_ready | in_busy;
    assign elig = bus.req & ~lock_q;
    assign release_c = in_busy && !bus.req[owner];
    // Release wins a tie with the limit, so revoke requires req still high.
    assign revoke = in_busy && bus.req[owner] && HOLD_MAX != 0 && cnt_q == CNT_W'(HOLD_MAX - 1);

    always_comb begin
        skip_ptr = ptr_q;
        found = 1'b0;
        idx = '0;
        for (int j = 1; j < N_CLIENTS; j++) begin
            idx = PTR_W'((int'(ptr_q) + j) % N_CLIENTS);
            if (!found && elig[idx]) begin
                skip_ptr = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        st_d = st_q;
        ptr_d = ptr_q;
        cnt_d = in_busy ? cnt_q + 1'b1 : '0;
        lock_d = lock_q & bus.req;
        preempt_d = 1'b0;
        if (!busy) begin
            if (elig[ptr_q]) st_d[ptr_q] = READY;
            else ptr_d = SKIP_IDLE ? skip_ptr : nxt(ptr_q);
        end else if (in_ready) st_d[owner] = BUSY;
        else if (release_c || revoke) begin
            st_d[owner] = IDLE;
            ptr_d = nxt(owner);
            lock_d[owner] = lock_d[owner] | revoke;
            preempt_d = revoke;
        end
    end

    assign bus.ack = ack;
    assign bus.sel = ptr_q;
    assign bus.busy = busy;
    assign bus.owner = owner;
    assign bus.preempt = preempt_q;
endmodule
